// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared state encoding and constants for the ID-stage hazard
//            controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_STALL = 1'b1;

    localparam int REG_ZERO = 0;
    localparam int CNT_W    = 3;

    typedef enum logic {
        S_RUN   = ST_RUN,
        S_STALL = ST_STALL
    } state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_reg_match.sv
// ============================================================================
// Module   : reg_match
// Purpose  : Flags whether either used ID source register equals a
//            destination register; register 0 never matches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ID_RegRs,
    input  logic [REG_AW-1:0] ID_RegRt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic [REG_AW-1:0] Dest,
    output logic              match
);

    logic w_m_rs;
    logic w_m_rt;

    assign w_m_rs = ID_UsesRs && (ID_RegRs != REG_AW'(REG_ZERO)) && (ID_RegRs == Dest);
    assign w_m_rt = ID_UsesRt && (ID_RegRt != REG_AW'(REG_ZERO)) && (ID_RegRt == Dest);
    assign match  = w_m_rs || w_m_rt;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : ID-stage load-use / branch-operand hazard controller with
//            multi-cycle load stall counter and memory-busy freeze.
//            Optional performance counters: define HAZARD_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [REG_AW-1:0] ID_RegRs,
    input  logic [REG_AW-1:0] ID_RegRt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_IsBranch,
    input  logic              BranchTaken,
    input  logic              EX_RegWrite,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_WriteReg,
    input  logic              MEM_MemRead,
    input  logic [REG_AW-1:0] MEM_WriteReg,
    input  logic              MemBusy,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              ID_EX_Bubble,
    output logic              IF_ID_Flush,
    output logic              Freeze,
    output logic [CNT_W-1:0]  StallCnt
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       StallCycles,
    output logic [31:0]       FlushCount
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_reload;

    logic w_br_en;
    logic w_match_ex;
    logic w_match_mem;
    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;
    logic w_hazard;

    reg_match #(.REG_AW(REG_AW)) u_match_ex (
        .ID_RegRs  (ID_RegRs),
        .ID_RegRt  (ID_RegRt),
        .ID_UsesRs (ID_UsesRs),
        .ID_UsesRt (ID_UsesRt),
        .Dest      (EX_WriteReg),
        .match     (w_match_ex)
    );

    reg_match #(.REG_AW(REG_AW)) u_match_mem (
        .ID_RegRs  (ID_RegRs),
        .ID_RegRt  (ID_RegRt),
        .ID_UsesRs (ID_UsesRs),
        .ID_UsesRt (ID_UsesRt),
        .Dest      (MEM_WriteReg),
        .match     (w_match_mem)
    );

    assign w_br_en    = (BRANCH_IN_ID != 0);
    assign w_load_use = EX_MemRead && w_match_ex;
    assign w_br_ex    = w_br_en && ID_IsBranch && EX_RegWrite && !EX_MemRead && w_match_ex;
    assign w_br_mem   = w_br_en && ID_IsBranch && MEM_MemRead && w_match_mem;
    assign w_hazard   = w_load_use || w_br_ex || w_br_mem;

    // A branch waiting on a load needs the loaded value one cycle earlier
    // than an ALU consumer, hence the extra stall cycle.
    always_comb begin
        w_reload = '0;
        if (w_load_use) begin
            if (ID_IsBranch && w_br_en) begin
                w_reload = CNT_W'(LOAD_LAT);
            end else begin
                w_reload = CNT_W'(LOAD_LAT - 1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Freeze       = 1'b0;

        if (!Rst_n) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (MemBusy) begin
            Freeze      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_hazard) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        if (w_reload != '0) begin
                            w_state_nxt = S_STALL;
                            w_cnt_nxt   = w_reload;
                        end else begin
                            w_cnt_nxt = '0;
                        end
                    end else begin
                        IF_ID_Flush = BranchTaken;
                    end
                end
                S_STALL: begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign StallCnt = r_cnt;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (ID_EX_Bubble && !Freeze) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (IF_ID_Flush && !Freeze) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed self-checking bench; two instances (LOAD_LAT=3 and 1)
//            share stimulus and are checked against hand-computed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    // Output vector: {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Freeze, StallCnt[2:0]}
    localparam logic [7:0] c_RST = 8'b00100_000;
    localparam logic [7:0] c_NRM = 8'b11000_000;
    localparam logic [7:0] c_FLS = 8'b11010_000;
    localparam logic [7:0] c_ST0 = 8'b00100_000;
    localparam logic [7:0] c_ST1 = 8'b00100_001;
    localparam logic [7:0] c_ST2 = 8'b00100_010;
    localparam logic [7:0] c_ST3 = 8'b00100_011;
    localparam logic [7:0] c_FZ0 = 8'b00001_000;
    localparam logic [7:0] c_FZ2 = 8'b00001_010;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] ID_RegRs, ID_RegRt, EX_WriteReg, MEM_WriteReg;
    logic       ID_UsesRs, ID_UsesRt, ID_IsBranch, BranchTaken;
    logic       EX_RegWrite, EX_MemRead, MEM_MemRead, MemBusy;

    logic       pc3, ifw3, bub3, fl3, fz3;
    logic [2:0] cnt3;
    logic       pc1, ifw1, bub1, fl1, fz1;
    logic [2:0] cnt1;
    logic [7:0] w_out3, w_out1;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc3, fc3, sc1, fc1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BRANCH_IN_ID(1)) u_dut_l3 (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .BranchTaken(BranchTaken),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .MemBusy(MemBusy),
        .PCWrite(pc3), .IF_ID_Write(ifw3), .ID_EX_Bubble(bub3),
        .IF_ID_Flush(fl3), .Freeze(fz3), .StallCnt(cnt3)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(sc3), .FlushCount(fc3)
`endif
    );

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BRANCH_IN_ID(1)) u_dut_l1 (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .BranchTaken(BranchTaken),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .MemBusy(MemBusy),
        .PCWrite(pc1), .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1),
        .IF_ID_Flush(fl1), .Freeze(fz1), .StallCnt(cnt1)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(sc1), .FlushCount(fc1)
`endif
    );

    assign w_out3 = {pc3, ifw3, bub3, fl3, fz3, cnt3};
    assign w_out1 = {pc1, ifw1, bub1, fl1, fz1, cnt1};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Check both instances mid-cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [7:0] e3, input logic [7:0] e1);
        @(negedge Clk);
        chk({tag, "/L3"}, w_out3, e3);
        chk({tag, "/L1"}, w_out1, e1);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ID_RegRs = '0; ID_RegRt = '0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        ID_IsBranch = 1'b0; BranchTaken = 1'b0;
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = '0;
        MEM_MemRead = 1'b0; MEM_WriteReg = '0; MemBusy = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] r);
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = r;
        ID_RegRs = r; ID_UsesRs = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b0;
        idle();
        @(posedge Clk);
        #1;
        cyc("reset", c_RST, c_RST);
        Rst_n = 1'b1;
        cyc("idle", c_NRM, c_NRM);

        // Plain load-use
        load_use(5'd8);
        cyc("lu_detect", c_ST0, c_ST0);
        idle();
        cyc("lu_s1", c_ST2, c_NRM);
        cyc("lu_s2", c_ST1, c_NRM);
        cyc("lu_done", c_NRM, c_NRM);

        // Register 0 and unused rt never match
        EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_RegRs = 5'd0; ID_UsesRs = 1'b1;
        cyc("r0", c_NRM, c_NRM);
        EX_WriteReg = 5'd9; ID_RegRs = 5'd3; ID_RegRt = 5'd9; ID_UsesRt = 1'b0;
        cyc("rt_unused", c_NRM, c_NRM);
        idle();

        // ALU result feeding a branch in ID
        ID_IsBranch = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd5;
        ID_RegRt = 5'd5; ID_UsesRt = 1'b1; BranchTaken = 1'b1;
        cyc("br_ex", c_ST0, c_ST0);
        EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        cyc("br_flush", c_FLS, c_FLS);
        idle();

        // Load in MEM feeding a branch
        ID_IsBranch = 1'b1; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd7;
        ID_RegRs = 5'd7; ID_UsesRs = 1'b1;
        cyc("br_mem", c_ST0, c_ST0);
        idle();
        cyc("br_mem_done", c_NRM, c_NRM);

        // Load-use into a branch: one extra stall cycle
        load_use(5'd4);
        ID_IsBranch = 1'b1;
        cyc("lub_detect", c_ST0, c_ST0);
        idle();
        cyc("lub_s1", c_ST3, c_ST1);
        cyc("lub_s2", c_ST2, c_NRM);
        cyc("lub_s3", c_ST1, c_NRM);
        cyc("lub_done", c_NRM, c_NRM);

        // Freeze in RUN suppresses detection entirely
        load_use(5'd6);
        MemBusy = 1'b1;
        cyc("fz_run", c_FZ0, c_FZ0);
        idle();
        cyc("fz_run_after", c_NRM, c_NRM);

        // Freeze mid-stall holds the counter
        load_use(5'd8);
        cyc("fzs_detect", c_ST0, c_ST0);
        idle();
        MemBusy = 1'b1;
        cyc("fzs_busy1", c_FZ2, c_FZ0);
        cyc("fzs_busy2", c_FZ2, c_FZ0);
        MemBusy = 1'b0;
        cyc("fzs_s1", c_ST2, c_NRM);
        cyc("fzs_s2", c_ST1, c_NRM);
        cyc("fzs_done", c_NRM, c_NRM);

        // Asynchronous reset while StallCnt=1
        load_use(5'd8);
        cyc("rst_detect", c_ST0, c_ST0);
        idle();
        cyc("rst_s1", c_ST2, c_NRM);
        @(negedge Clk);
        chk("rst_pre/L3", w_out3, c_ST1);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("rst_async/L3", w_out3, c_RST);
        chk("rst_async/L1", w_out1, c_RST);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        cyc("rst_release", c_NRM, c_NRM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
